ddr3_init_seq: RTL and testbench
================================

Name: ddr3_init_seq

Overview:
- Power-up and mode-register initialization sequencer for the DDR3 memory controller.
- Drives the device reset pin, CKE and the command bus through the JEDEC init order: reset hold, CKE wait, tXPR, then MRS MR2, MR3, MR1, MR0, then ZQCL.
- Raises done when complete. The main controller FSM stays in INIT until done, then moves to IDLE.

Parameters:
- T_RESET_CYC, 200, cycles ddr_rst_n is held low (>=1)
- T_CKE_CYC, 500, cycles after ddr_rst_n rises before cke asserts (>=1)
- T_XPR, 120, NOP cycles with cke=1 before the first MRS (>=1)
- T_MRD, 4, MRS-to-MRS command spacing in cycles (>=1)
- T_MOD, 12, MR0 MRS-to-ZQCL spacing in cycles (>=1)
- T_ZQINIT, 512, ZQCL-to-done spacing in cycles (>=1)

Ports:
- clk  in  1  controller clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  single-cycle request to run the init sequence
- mr0_val  in  16  MR0 address-bus payload
- mr1_val  in  16  MR1 payload
- mr2_val  in  16  MR2 payload
- mr3_val  in  16  MR3 payload
- ddr_rst_n  out  1  DRAM RESET#
- cke  out  1  DRAM clock enable
- cs_n, ras_n, cas_n, we_n  out  1 each  DRAM command pins
- ba  out  3  bank address
- addr  out  16  address bus
- busy  out  1  sequence in progress
- done  out  1  init complete (sticky)

Behaviour:
- All outputs are registered.
- Reset values (async, immediate): ddr_rst_n=0, cke=0, cs_n=ras_n=cas_n=we_n=1, ba=0, addr=0, busy=0, done=0, state=S_IDLE.
- Command encodings:
  - NOP: cs_n=0, ras_n=1, cas_n=1, we_n=1, ba=0, addr=0.
  - MRS: all four pins 0, ba=register index, addr=payload.
  - ZQCL: cs_n=0, ras_n=1, cas_n=1, we_n=0, addr[10]=1, all other addr bits 0, ba=0.
- In S_IDLE and S_RST_HOLD the command pins are deselected (cs_n=1, others 1).
- On start=1 in S_IDLE or S_DONE: latch mr0..mr3_val, set busy=1, clear done, go to S_RST_HOLD.
- start is ignored while busy=1.
- mr*_val changes after the latch cycle have no effect.
- State sequence, with "cycle k" = k clock edges after start is sampled:
  - S_RST_HOLD: ddr_rst_n=0 for T_RESET_CYC cycles (cycles 1..T_RESET_CYC).
  - S_CKE_WAIT: ddr_rst_n=1, cke=0, deselect, for T_CKE_CYC cycles.
  - S_XPR: cke=1, NOP, for T_XPR cycles.
  - S_MRS: one MRS cycle. Index order is 2, 3, 1, 0, with ba = index.
  - S_MRD_WAIT: T_MRD-1 NOP cycles, then the next S_MRS. After MR0, wait T_MOD-1 NOP cycles instead and go to S_ZQCL.
  - S_ZQCL: one ZQCL cycle.
  - S_ZQ_WAIT: T_ZQINIT-1 NOP cycles.
  - S_DONE: done=1, busy=0, NOP continues, cke=1, ddr_rst_n=1.
- A wait parameter of 1 means zero NOP cycles between commands, so commands are back-to-back.
- A single 16-bit down-counter is shared by all wait states. It is loaded on state entry and the state exits when it reaches 0.
- A 2-bit MRS index counter steps through the four registers.
- Reset asserted mid-sequence aborts immediately to the reset values. The next start restarts from S_RST_HOLD.
- Restart from S_DONE reruns the full sequence, including the reset pulse.

Optional Feature:
- Macro: DDR3_INIT_DLL_RESET_EN.
- Defined: the MR0 MRS is issued with addr[8] forced to 1 (DLL reset), regardless of mr0_val[8]. All other bits pass through.
- Undefined: MR0 is issued exactly as latched.
- Timing is identical in both cases.

Test Plan:
- Bench parameters for all scenarios: T_RESET_CYC=4, T_CKE_CYC=3, T_XPR=5, T_MRD=4, T_MOD=6, T_ZQINIT=8.
- Full sequence: mr0=16'h0520, mr1=16'h0044, mr2=16'h0008, mr3=0, start at cycle 0 -> ddr_rst_n low cycles 1-4, high from 5; cke high from 8; MRS ba=2 addr=0008 at 13, ba=3 at 17, ba=1 addr=0044 at 21, ba=0 addr=0520 at 25; ZQCL (addr=16'h0400) at 31; done=1, busy=0 at 39; NOP on all other cycles from 8.
- start pulses at cycles 10 and 20 while busy -> ignored; timeline identical to the full-sequence scenario.
- Change mr1_val to 16'hFFFF at cycle 5 -> MR1 still issued with addr=0044 at cycle 21.
- Assert reset at cycle 18 -> outputs return to reset values the same cycle; start after reset release reproduces the full timeline relative to the new start.
- After done, start again -> done clears the next cycle, ddr_rst_n pulses low for 4 cycles, done reasserts 39 cycles after the second start.
- With DDR3_INIT_DLL_RESET_EN and mr0=16'h0020 -> MR0 at cycle 25 has addr=16'h0120. Without the macro -> addr=16'h0020.

Source files
------------

// File: rtl/ddr3_init_seq.sv
// DDR3 power-up and mode-register initialization sequencer.
// Optional build macro DDR3_INIT_DLL_RESET_EN forces the DLL-reset bit (addr[8]) in the MR0 MRS.
module ddr3_init_seq #(
  parameter int unsigned T_RESET_CYC = 200,
  parameter int unsigned T_CKE_CYC   = 500,
  parameter int unsigned T_XPR       = 120,
  parameter int unsigned T_MRD       = 4,
  parameter int unsigned T_MOD       = 12,
  parameter int unsigned T_ZQINIT    = 512
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] mr0_val,
  input  logic [15:0] mr1_val,
  input  logic [15:0] mr2_val,
  input  logic [15:0] mr3_val,
  output logic        ddr_rst_n,
  output logic        cke,
  output logic        cs_n,
  output logic        ras_n,
  output logic        cas_n,
  output logic        we_n,
  output logic [2:0]  ba,
  output logic [15:0] addr,
  output logic        busy,
  output logic        done
);

  localparam int unsigned CNT_W = 16;

  // Wait states last N cycles: the counter is loaded with N-1 on entry, exit at 0.
  // MRD/MOD/ZQ waits hold N-1 NOP cycles after a command, hence N-2.
  localparam logic [CNT_W-1:0] RST_LD = CNT_W'(T_RESET_CYC - 1);
  localparam logic [CNT_W-1:0] CKE_LD = CNT_W'(T_CKE_CYC - 1);
  localparam logic [CNT_W-1:0] XPR_LD = CNT_W'(T_XPR - 1);
  localparam logic [CNT_W-1:0] MRD_LD = CNT_W'(T_MRD - 2);
  localparam logic [CNT_W-1:0] MOD_LD = CNT_W'(T_MOD - 2);
  localparam logic [CNT_W-1:0] ZQ_LD  = CNT_W'(T_ZQINIT - 2);

  typedef enum logic [3:0] {
    S_IDLE, S_RST_HOLD, S_CKE_WAIT, S_XPR, S_MRS,
    S_MRD_WAIT, S_ZQCL, S_ZQ_WAIT, S_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]       mrs_idx, mrs_idx_nxt;
  logic             latch_c;
  logic [15:0]      mr0_q, mr1_q, mr2_q, mr3_q;

  logic        ddr_rst_n_c, cke_c, cs_n_c, ras_n_c, cas_n_c, we_n_c, busy_c, done_c;
  logic [2:0]  ba_c;
  logic [15:0] addr_c, mr0_issue_c;

  // State, counters and latched mode-register payloads
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      mrs_idx <= '0;
      mr0_q   <= '0;
      mr1_q   <= '0;
      mr2_q   <= '0;
      mr3_q   <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      mrs_idx <= mrs_idx_nxt;
      if (latch_c) begin
        mr0_q <= mr0_val;
        mr1_q <= mr1_val;
        mr2_q <= mr2_val;
        mr3_q <= mr3_val;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    mrs_idx_nxt = mrs_idx;
    latch_c     = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_nxt   = S_RST_HOLD;
          cnt_nxt     = RST_LD;
          mrs_idx_nxt = 2'd0;
          latch_c     = 1'b1;
        end
      end
      S_RST_HOLD: begin
        if (cnt == '0) begin
          state_nxt = S_CKE_WAIT;
          cnt_nxt   = CKE_LD;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      S_CKE_WAIT: begin
        if (cnt == '0) begin
          state_nxt = S_XPR;
          cnt_nxt   = XPR_LD;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      S_XPR: begin
        if (cnt == '0) state_nxt = S_MRS;
        else           cnt_nxt   = cnt - CNT_W'(1);
      end
      S_MRS: begin
        mrs_idx_nxt = mrs_idx + 2'd1;
        if (mrs_idx == 2'd3) begin
          if (T_MOD > 1) begin
            state_nxt = S_MRD_WAIT;
            cnt_nxt   = MOD_LD;
          end else begin
            state_nxt = S_ZQCL;
          end
        end else if (T_MRD > 1) begin
          state_nxt = S_MRD_WAIT;
          cnt_nxt   = MRD_LD;
        end
      end
      S_MRD_WAIT: begin
        // Index wraps to 0 once MR0 has gone out
        if (cnt == '0) state_nxt = (mrs_idx == 2'd0) ? S_ZQCL : S_MRS;
        else           cnt_nxt   = cnt - CNT_W'(1);
      end
      S_ZQCL: begin
        if (T_ZQINIT > 1) begin
          state_nxt = S_ZQ_WAIT;
          cnt_nxt   = ZQ_LD;
        end else begin
          state_nxt = S_DONE;
        end
      end
      S_ZQ_WAIT: begin
        if (cnt == '0) state_nxt = S_DONE;
        else           cnt_nxt   = cnt - CNT_W'(1);
      end
      default: state_nxt = S_IDLE;
    endcase
  end

`ifdef DDR3_INIT_DLL_RESET_EN
  assign mr0_issue_c = mr0_q | 16'h0100;
`else
  assign mr0_issue_c = mr0_q;
`endif

  // Pin values for the current state; registered below
  always_comb begin
    ddr_rst_n_c = 1'b1;
    cke_c       = 1'b1;
    cs_n_c      = 1'b0;
    ras_n_c     = 1'b1;
    cas_n_c     = 1'b1;
    we_n_c      = 1'b1;
    ba_c        = 3'd0;
    addr_c      = 16'h0000;
    busy_c      = 1'b1;
    done_c      = 1'b0;
    case (state)
      S_RST_HOLD: begin
        ddr_rst_n_c = 1'b0;
        cke_c       = 1'b0;
        cs_n_c      = 1'b1;
      end
      S_CKE_WAIT: begin
        cke_c  = 1'b0;
        cs_n_c = 1'b1;
      end
      S_XPR, S_MRD_WAIT, S_ZQ_WAIT: ;
      S_MRS: begin
        ras_n_c = 1'b0;
        cas_n_c = 1'b0;
        we_n_c  = 1'b0;
        case (mrs_idx)
          2'd0:    begin ba_c = 3'd2; addr_c = mr2_q;       end
          2'd1:    begin ba_c = 3'd3; addr_c = mr3_q;       end
          2'd2:    begin ba_c = 3'd1; addr_c = mr1_q;       end
          default: begin ba_c = 3'd0; addr_c = mr0_issue_c; end
        endcase
      end
      S_ZQCL: begin
        we_n_c = 1'b0;
        addr_c = 16'h0400;
      end
      S_DONE: begin
        busy_c = 1'b0;
        done_c = 1'b1;
      end
      default: begin
        ddr_rst_n_c = 1'b0;
        cke_c       = 1'b0;
        cs_n_c      = 1'b1;
        busy_c      = 1'b0;
      end
    endcase
  end

  // Output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ddr_rst_n <= 1'b0;
      cke       <= 1'b0;
      cs_n      <= 1'b1;
      ras_n     <= 1'b1;
      cas_n     <= 1'b1;
      we_n      <= 1'b1;
      ba        <= 3'd0;
      addr      <= 16'h0000;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      ddr_rst_n <= ddr_rst_n_c;
      cke       <= cke_c;
      cs_n      <= cs_n_c;
      ras_n     <= ras_n_c;
      cas_n     <= cas_n_c;
      we_n      <= we_n_c;
      ba        <= ba_c;
      addr      <= addr_c;
      busy      <= busy_c;
      done      <= done_c;
    end
  end

endmodule

// File: tb/tb_ddr3_init_seq.sv
// Self-checking bench for ddr3_init_seq: per-cycle expected pin vectors queued at start, compared every cycle.
module tb_ddr3_init_seq;

  typedef struct packed {
    logic        rst_n;
    logic        cke;
    logic        cs_n;
    logic        ras_n;
    logic        cas_n;
    logic        we_n;
    logic [2:0]  ba;
    logic [15:0] addr;
    logic        busy;
    logic        done;
  } pins_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] mr0_val = 16'h0520;
  logic [15:0] mr1_val = 16'h0044;
  logic [15:0] mr2_val = 16'h0008;
  logic [15:0] mr3_val = 16'h0000;
  logic        ddr_rst_n, cke, cs_n, ras_n, cas_n, we_n, busy, done;
  logic [2:0]  ba;
  logic [15:0] addr;

  int    compared = 0;
  int    mismatched = 0;
  pins_t exp_q[$];

  ddr3_init_seq #(
    .T_RESET_CYC(4), .T_CKE_CYC(3), .T_XPR(5),
    .T_MRD(4), .T_MOD(6), .T_ZQINIT(8)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .mr0_val(mr0_val), .mr1_val(mr1_val), .mr2_val(mr2_val), .mr3_val(mr3_val),
    .ddr_rst_n(ddr_rst_n), .cke(cke), .cs_n(cs_n), .ras_n(ras_n), .cas_n(cas_n),
    .we_n(we_n), .ba(ba), .addr(addr), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic pins_t idle_pins();
    pins_t p;
    p = '0;
    p.cs_n = 1'b1; p.ras_n = 1'b1; p.cas_n = 1'b1; p.we_n = 1'b1;
    return p;
  endfunction

  function automatic pins_t done_pins();
    pins_t p;
    p = '0;
    p.rst_n = 1'b1; p.cke = 1'b1;
    p.ras_n = 1'b1; p.cas_n = 1'b1; p.we_n = 1'b1;
    p.done = 1'b1;
    return p;
  endfunction

  // Expected pins k cycles after start was sampled, from the documented timeline
  function automatic pins_t exp_at(int k, bit from_done, logic [15:0] m0, logic [15:0] m1,
                                   logic [15:0] m2, logic [15:0] m3);
    pins_t p;
    logic [15:0] m0_eff;
    m0_eff = m0;
`ifdef DDR3_INIT_DLL_RESET_EN
    m0_eff[8] = 1'b1;
`endif
    if (k == 0) return from_done ? done_pins() : idle_pins();
    if (k >= 39) return done_pins();
    p = '0;
    p.rst_n = 1'b1; p.cke = 1'b1;
    p.ras_n = 1'b1; p.cas_n = 1'b1; p.we_n = 1'b1;
    p.busy = 1'b1;
    if (k <= 4) begin
      p.rst_n = 1'b0; p.cke = 1'b0; p.cs_n = 1'b1;
    end else if (k <= 7) begin
      p.cke = 1'b0; p.cs_n = 1'b1;
    end else begin
      case (k)
        13: begin p.ras_n = 0; p.cas_n = 0; p.we_n = 0; p.ba = 3'd2; p.addr = m2; end
        17: begin p.ras_n = 0; p.cas_n = 0; p.we_n = 0; p.ba = 3'd3; p.addr = m3; end
        21: begin p.ras_n = 0; p.cas_n = 0; p.we_n = 0; p.ba = 3'd1; p.addr = m1; end
        25: begin p.ras_n = 0; p.cas_n = 0; p.we_n = 0; p.ba = 3'd0; p.addr = m0_eff; end
        31: begin p.we_n = 0; p.addr = 16'h0400; end
        default: ;
      endcase
    end
    return p;
  endfunction

  task automatic check_next(input string tag);
    pins_t obs, exp;
    obs = '{ddr_rst_n, cke, cs_n, ras_n, cas_n, we_n, ba, addr, busy, done};
    compared++;
    if (exp_q.size() == 0) begin
      mismatched++;
      $error("FAIL %s: scoreboard empty, observed %h", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        mismatched++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
    end
  endtask

  // scen: 0 plain, 1 extra starts while busy, 2 mr1 change after latch, 3 reset abort at cycle 18
  task automatic run_seq(input int scen, input bit from_done, input int last_k);
    logic [15:0] m0, m1, m2, m3;
    @(negedge clk);
    start = 1'b1;
    m0 = mr0_val; m1 = mr1_val; m2 = mr2_val; m3 = mr3_val;
    for (int k = 0; k <= last_k; k++) exp_q.push_back(exp_at(k, from_done, m0, m1, m2, m3));
    for (int k = 0; k <= last_k; k++) begin
      @(negedge clk);
      start = 1'b0;
      check_next($sformatf("scen%0d cyc%0d", scen, k));
      if (scen == 1 && (k == 9 || k == 19)) start = 1'b1;
      if (scen == 2 && k == 5) mr1_val = 16'hFFFF;
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    exp_q.push_back(idle_pins());
    check_next("in_reset");
    reset = 1'b0;
    @(negedge clk);
    exp_q.push_back(idle_pins());
    check_next("idle_after_reset");

    run_seq(0, 1'b0, 42);

    run_seq(1, 1'b1, 41);

    mr0_val = 16'h0020;
    run_seq(2, 1'b1, 41);
    mr1_val = 16'h0044;
    mr0_val = 16'h0520;

    run_seq(3, 1'b1, 18);
    #1 reset = 1'b1;
    #1;
    exp_q.push_back(idle_pins());
    check_next("async_reset_abort");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    exp_q.push_back(idle_pins());
    check_next("idle_after_abort");

    run_seq(0, 1'b0, 40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
